dwconv_stream: RTL

DWCONV_STREAM -- requirements
Module: dwconv_stream

---
 rtl/dwconv_pkg.sv | 19 +
 rtl/dwconv_linebuf.sv | 29 ++
 rtl/dwconv_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dwconv_pkg.sv
// Shared types and accumulator sizing for the 3x3 streaming convolution.
// Consumers: dwconv_stream (optional ReLU via DWCONV_STREAM_RELU_EN).
package dwconv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN
    } dw_state_e;

    // Nine full-width products plus a bias need four bits of headroom.
    localparam int ACC_GUARD = 4;

    function automatic int acc_width(input int data_w);
        return 2 * data_w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/dwconv_linebuf.sv
// Two-row line buffer addressed by column: returns rows r-1 and r-2 at addr,
// and on write shifts the column down one row.
module dwconv_linebuf #(
    parameter int IMG_W  = 176,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] row_m1,
    output logic signed [DATA_W-1:0] row_m2
);

    logic signed [DATA_W-1:0] mem_m1 [IMG_W];
    logic signed [DATA_W-1:0] mem_m2 [IMG_W];

    assign row_m1 = mem_m1[addr];
    assign row_m2 = mem_m2[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_m1[addr] <= din;
            mem_m2[addr] <= mem_m1[addr];
        end
    end

endmodule

// File: rtl/dwconv_stream.sv
// Streaming 3x3 valid-mode convolution with stride 1/2, two-stage arithmetic
// pipeline and backpressure. Define DWCONV_STREAM_RELU_EN to clamp negatives to 0.
module dwconv_stream
    import dwconv_pkg::*;
#(
    parameter int IMG_W  = 176,
    parameter int IMG_H  = 120,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 21,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_stride2,
    input  logic [9*DATA_W-1:0]      weight,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int ACC_W  = acc_width(DATA_W);
    localparam int PROD_W = 2 * DATA_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO   = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO   = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_LAST2 = COL_W'(((IMG_W - 1) % 2 == 0) ? IMG_W - 1 : IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_LAST2 = ROW_W'(((IMG_H - 1) % 2 == 0) ? IMG_H - 1 : IMG_H - 2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    dw_state_e                 state_reg;
    logic [COL_W-1:0]          col_reg;
    logic [ROW_W-1:0]          row_reg;
    logic signed [DATA_W-1:0]  win_reg [3][3];
    logic [9*DATA_W-1:0]       weight_reg;
    logic signed [DATA_W-1:0]  bias_reg;
    logic                      stride2_reg;
    logic signed [PROD_W-1:0]  prod_reg [9];
    logic                      s1_valid_reg, s1_last_reg;
    logic                      out_valid_reg, out_last_reg;
    logic signed [OUT_W-1:0]   out_data_reg;

    logic                      stall, accept, frame_start, last_pixel, win_valid, win_last;
    logic signed [DATA_W-1:0]  lb_m1, lb_m2;
    logic signed [DATA_W-1:0]  new_col [3];
    logic signed [PROD_W-1:0]  tap_prod [9];
    logic signed [ACC_W-1:0]   acc_sum, acc_shift;
    logic signed [OUT_W-1:0]   sat_val, res_val;

    assign stall       = out_valid_reg && !out_ready;
    assign in_ready    = rst_n && !stall && (state_reg != ST_DRAIN);
    assign accept      = in_valid && in_ready;
    assign frame_start = (row_reg == '0) && (col_reg == '0);
    assign last_pixel  = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
    // Coordinates are those of the pixel completing the window (its bottom-right tap).
    assign win_valid   = (row_reg >= ROW_TWO) && (col_reg >= COL_TWO) &&
                         (!stride2_reg || (!row_reg[0] && !col_reg[0]));
    assign win_last    = stride2_reg ? ((row_reg == ROW_LAST2) && (col_reg == COL_LAST2)) : last_pixel;

    dwconv_linebuf #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_linebuf (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (col_reg),
        .din    (in_data),
        .row_m1 (lb_m1),
        .row_m2 (lb_m2)
    );

    assign new_col[0] = lb_m2;
    assign new_col[1] = lb_m1;
    assign new_col[2] = in_data;

    // Products use the window as it will be after this pixel shifts in.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            logic signed [DATA_W-1:0] tap_pix;
            logic signed [DATA_W-1:0] tap_wt;
            if (gi % 3 == 2) begin : g_new
                assign tap_pix = new_col[gi / 3];
            end else begin : g_old
                assign tap_pix = win_reg[gi / 3][gi % 3 + 1];
            end
            assign tap_wt      = $signed(weight_reg[gi*DATA_W +: DATA_W]);
            assign tap_prod[gi] = PROD_W'(tap_pix) * PROD_W'(tap_wt);
        end
    endgenerate

    always_comb begin
        acc_sum = ACC_W'(bias_reg);
        for (int k = 0; k < 9; k++) begin
            acc_sum = acc_sum + ACC_W'(prod_reg[k]);
        end
        acc_shift = acc_sum >>> SHIFT;
        if (acc_shift > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = acc_shift[OUT_W-1:0];
        end
`ifdef DWCONV_STREAM_RELU_EN
        res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            weight_reg    <= '0;
            bias_reg      <= '0;
            stride2_reg   <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
            for (int k = 0; k < 9; k++) begin
                prod_reg[k] <= '0;
            end
        end else begin
            if (accept) begin
                if (col_reg == COL_MAX) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
                if (frame_start) begin
                    weight_reg  <= weight;
                    bias_reg    <= bias;
                    stride2_reg <= cfg_stride2;
                end
                for (int r = 0; r < 3; r++) begin
                    win_reg[r][0] <= win_reg[r][1];
                    win_reg[r][1] <= win_reg[r][2];
                    win_reg[r][2] <= new_col[r];
                end
            end
            if (!stall) begin
                s1_valid_reg  <= accept && win_valid;
                s1_last_reg   <= accept && win_valid && win_last;
                prod_reg      <= tap_prod;
                out_valid_reg <= s1_valid_reg;
                out_last_reg  <= s1_last_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= res_val;
                end
            end
            case (state_reg)
                ST_IDLE:  if (accept) state_reg <= ST_FILL;
                ST_FILL: begin
                    if (accept && last_pixel) begin
                        state_reg <= ST_DRAIN;
                    end else if (accept && row_reg == ROW_TWO && col_reg == COL_TWO) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN:   if (accept && last_pixel) state_reg <= ST_DRAIN;
                ST_DRAIN: if (!s1_valid_reg && !out_valid_reg) state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
